// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: icache/dcache request ports and RAM port shared through the arbiter
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single-ported RAM to dcache or icache, data first with a starvation escape for instructions
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;
  state_t state, next_state;
  logic [CW-1:0] starve_cnt;
  logic dreq, access, i_done, d_done;
  assign dreq = bus.dREN | bus.dWEN;
  assign access = bus.ramstate == 2'd2;
  assign i_done = state == IGRANT && bus.iREN && access;
  assign d_done = state == DGRANT && dreq && access;
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      starve_cnt <= '0;
    end else begin
      state <= next_state;
      if (!bus.iREN || i_done) starve_cnt <= '0;
      else if (d_done && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
    end
  // A dropped request aborts the grant combinationally; no wait pulse is produced.
  always_comb begin
    next_state = state;
    bus.iwait = 1'b1;
    bus.dwait = 1'b1;
    bus.ramREN = 1'b0;
    bus.ramWEN = 1'b0;
    bus.ramaddr = '0;
    bus.ramstore = '0;
    case (state)
      IDLE: next_state = (dreq && bus.iREN && starve_cnt == LIMIT) ? IGRANT :
                         dreq ? DGRANT : bus.iREN ? IGRANT : IDLE;
      IGRANT:
        if (!bus.iREN) next_state = IDLE;
        else begin
          bus.ramREN = 1'b1;
          bus.ramaddr = bus.iaddr;
          bus.iwait = !access;
          next_state = access ? IDLE : IGRANT;
        end
      DGRANT:
        if (!dreq) next_state = IDLE;
        else begin
          bus.ramWEN = bus.dWEN;
          bus.ramREN = !bus.dWEN;
          bus.ramaddr = bus.daddr;
          bus.ramstore = bus.dstore;
          bus.dwait = !access;
          next_state = access ? IDLE : DGRANT;
        end
      default: next_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario checks of the RAM arbiter
module tb_mem_arbiter;
  logic CLK = 1'b0;
  logic nRST;
  int checks = 0;
  int failures = 0;
  mem_arbiter_if bus();
  mem_arbiter #(.STARVE_LIMIT(4)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = 2'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 0;
    #12;
    checks++; if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin failures++; $display("FAIL reset_wait got i=%b d=%b exp 1 1", bus.iwait, bus.dwait); end
    checks++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin failures++; $display("FAIL reset_en got r=%b w=%b exp 0 0", bus.ramREN, bus.ramWEN); end
    checks++; if (bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0) begin failures++; $display("FAIL reset_bus got a=%h s=%h exp 0 0", bus.ramaddr, bus.ramstore); end
    checks++; if (dut.starve_cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", dut.starve_cnt); end
    tick(); nRST = 1;
  endtask

  task automatic test_i_only();
    tick(); bus.iREN = 1; bus.iaddr = 32'h40; #1;
    checks++; if (bus.ramREN !== 1'b0) begin failures++; $display("FAIL i_idle_ren got=%b exp=0", bus.ramREN); end
    for (int k = 0; k < 2; k++) begin
      tick(); bus.ramstate = 2'd1; #1;
      checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40 || bus.iwait !== 1'b1) begin failures++; $display("FAIL i_busy got ren=%b addr=%h iwait=%b exp 1 40 1", bus.ramREN, bus.ramaddr, bus.iwait); end
    end
    tick(); bus.ramstate = 2'd2; bus.ramload = 32'hDEADBEEF; #1;
    checks++; if (bus.iwait !== 1'b0 || bus.iload !== 32'hDEADBEEF || bus.dwait !== 1'b1) begin failures++; $display("FAIL i_access got iwait=%b iload=%h dwait=%b exp 0 deadbeef 1", bus.iwait, bus.iload, bus.dwait); end
    tick(); idle_inputs(); #1;
    checks++; if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin failures++; $display("FAIL i_after got ren=%b iwait=%b exp 0 1", bus.ramREN, bus.iwait); end
  endtask

  task automatic test_simultaneous();
    tick(); bus.iREN = 1; bus.iaddr = 32'h44; bus.dREN = 1; bus.daddr = 32'h200; #1;
    tick(); bus.ramstate = 2'd2; bus.ramload = 32'h11112222; #1;
    checks++; if (bus.ramaddr !== 32'h200 || bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0 || bus.iwait !== 1'b1) begin failures++; $display("FAIL sim_dgrant got addr=%h ren=%b wen=%b iwait=%b exp 200 1 0 1", bus.ramaddr, bus.ramREN, bus.ramWEN, bus.iwait); end
    checks++; if (bus.dwait !== 1'b0 || bus.dload !== 32'h11112222) begin failures++; $display("FAIL sim_dwait got dwait=%b dload=%h exp 0 11112222", bus.dwait, bus.dload); end
    tick(); bus.dREN = 0; bus.ramstate = 2'd0; #1;
    checks++; if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin failures++; $display("FAIL sim_gap got ren=%b iwait=%b exp 0 1", bus.ramREN, bus.iwait); end
    tick(); bus.ramstate = 2'd2; bus.ramload = 32'hCAFEF00D; #1;
    checks++; if (bus.ramaddr !== 32'h44 || bus.ramREN !== 1'b1 || bus.dwait !== 1'b1) begin failures++; $display("FAIL sim_igrant got addr=%h ren=%b dwait=%b exp 44 1 1", bus.ramaddr, bus.ramREN, bus.dwait); end
    checks++; if (bus.iwait !== 1'b0 || bus.iload !== 32'hCAFEF00D) begin failures++; $display("FAIL sim_iwait got iwait=%b iload=%h exp 0 cafef00d", bus.iwait, bus.iload); end
    tick(); idle_inputs();
  endtask

  task automatic test_starvation();
    tick(); bus.iREN = 1; bus.iaddr = 32'h80; bus.dWEN = 1; bus.daddr = 32'h300; bus.ramstate = 2'd2; #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.ramWEN !== 1'b0 || bus.ramREN !== 1'b0) begin failures++; $display("FAIL starve_idle%0d got wen=%b ren=%b exp 0 0", k, bus.ramWEN, bus.ramREN); end
      tick(); bus.dstore = 32'(k + 1); #1;
      checks++; if (bus.ramWEN !== 1'b1 || bus.dwait !== 1'b0 || bus.ramstore !== 32'(k + 1) || bus.iwait !== 1'b1) begin failures++; $display("FAIL starve_d%0d got wen=%b dwait=%b store=%h iwait=%b exp 1 0 %h 1", k, bus.ramWEN, bus.dwait, bus.ramstore, bus.iwait, k + 1); end
      tick(); #1;
    end
    checks++; if (dut.starve_cnt !== 3'd4) begin failures++; $display("FAIL starve_cnt_full got=%0d exp=4", dut.starve_cnt); end
    tick(); #1;
    checks++; if (bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h80 || bus.iwait !== 1'b0 || bus.dwait !== 1'b1) begin failures++; $display("FAIL starve_igrant got ren=%b wen=%b addr=%h iwait=%b dwait=%b exp 1 0 80 0 1", bus.ramREN, bus.ramWEN, bus.ramaddr, bus.iwait, bus.dwait); end
    tick(); #1;
    checks++; if (dut.starve_cnt !== 3'd0) begin failures++; $display("FAIL starve_cnt_clear got=%0d exp=0", dut.starve_cnt); end
    idle_inputs();
  endtask

  task automatic test_write_wins();
    tick(); bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'h12345678; #1;
    tick(); bus.ramstate = 2'd1; #1;
    checks++; if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramstore !== 32'h12345678 || bus.ramaddr !== 32'h100 || bus.dwait !== 1'b1) begin failures++; $display("FAIL ww_busy got wen=%b ren=%b store=%h addr=%h dwait=%b exp 1 0 12345678 100 1", bus.ramWEN, bus.ramREN, bus.ramstore, bus.ramaddr, bus.dwait); end
    tick(); bus.ramstate = 2'd3; #1;
    checks++; if (bus.ramWEN !== 1'b1 || bus.dwait !== 1'b1) begin failures++; $display("FAIL ww_error got wen=%b dwait=%b exp 1 1", bus.ramWEN, bus.dwait); end
    tick(); bus.ramstate = 2'd2; #1;
    checks++; if (bus.dwait !== 1'b0 || bus.ramWEN !== 1'b1) begin failures++; $display("FAIL ww_access got dwait=%b wen=%b exp 0 1", bus.dwait, bus.ramWEN); end
    tick(); idle_inputs();
  endtask

  task automatic test_abort();
    tick(); bus.dREN = 1; bus.daddr = 32'h500; #1;
    tick(); bus.ramstate = 2'd1; #1;
    checks++; if (bus.ramREN !== 1'b1) begin failures++; $display("FAIL ab_grant got ren=%b exp=1", bus.ramREN); end
    #2; bus.dREN = 0; #1;
    checks++; if (bus.ramREN !== 1'b0 || bus.dwait !== 1'b1 || bus.ramaddr !== 32'h0) begin failures++; $display("FAIL ab_drop got ren=%b dwait=%b addr=%h exp 0 1 0", bus.ramREN, bus.dwait, bus.ramaddr); end
    tick(); bus.dREN = 1; #1;
    checks++; if (bus.ramREN !== 1'b0 || bus.dwait !== 1'b1) begin failures++; $display("FAIL ab_idle got ren=%b dwait=%b exp 0 1", bus.ramREN, bus.dwait); end
    tick(); #1;
    checks++; if (bus.ramREN !== 1'b1) begin failures++; $display("FAIL ab_regrant got ren=%b exp=1", bus.ramREN); end
    bus.dREN = 0; tick(); idle_inputs();
  endtask

  task automatic test_async_reset();
    tick(); bus.iREN = 1; bus.iaddr = 32'h60; bus.ramstate = 2'd1; #1;
    tick(); #1;
    checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h60) begin failures++; $display("FAIL rst_grant got ren=%b addr=%h exp 1 60", bus.ramREN, bus.ramaddr); end
    #1; nRST = 0; #1;
    checks++; if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1 || bus.ramaddr !== 32'h0) begin failures++; $display("FAIL rst_async got ren=%b iwait=%b addr=%h exp 0 1 0", bus.ramREN, bus.iwait, bus.ramaddr); end
    tick(); nRST = 1; #1;
    checks++; if (bus.ramREN !== 1'b0) begin failures++; $display("FAIL rst_idle got ren=%b exp=0", bus.ramREN); end
    tick(); #1;
    checks++; if (bus.ramREN !== 1'b1) begin failures++; $display("FAIL rst_regrant got ren=%b exp=1", bus.ramREN); end
    bus.iREN = 0; tick(); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_simultaneous();
    test_starvation();
    test_write_wins();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
